gpu_framebuffer_dp: RTL and testbench

//  Parametrised dual-port GPU framebuffer; successor to the fixed 1200x64 character store.

---
 rtl/gpu_framebuffer_dp.sv | 148 ++++++++++++++
 tb/tb_gpu_framebuffer_dp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_framebuffer_dp.sv
// Dual-port framebuffer: CPU read/write port with byte enables, a scan-out engine
// streaming every word over valid/ready, and a clear engine that fills memory.
module gpu_framebuffer_dp #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    DEPTH       = 1200,
    parameter int                    ADDR_WIDTH  = 11,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_in,
    input  logic                    cpu_write,
    input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
    output logic [DATA_WIDTH-1:0]   cpu_out,
    input  logic                    clear_start,
    output logic                    clear_busy,
    input  logic                    scan_start,
    output logic                    scan_valid,
    input  logic                    scan_ready,
    output logic [DATA_WIDTH-1:0]   scan_data,
    output logic [ADDR_WIDTH-1:0]   scan_address,
    output logic                    scan_done
);

    localparam int                    NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_CLEAR} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_WIDTH-1:0] scan_ptr_q, scan_ptr_d;
    logic [ADDR_WIDTH-1:0] scan_address_q, scan_address_d;
    logic                  scan_valid_q, scan_valid_d;
    logic                  scan_done_q, scan_done_d;
    logic [DATA_WIDTH-1:0] scan_data_q;
    logic [DATA_WIDTH-1:0] cpu_out_q;

    logic cpu_in_range;
    logic cpu_wr_en;
    logic scan_load;
    logic scan_last_accept;

    assign cpu_in_range = 32'(cpu_address) < DEPTH;
    assign cpu_wr_en    = cpu_write && cpu_in_range && (state_q != ST_CLEAR);

    // The output register doubles as the read register: a new word is fetched
    // whenever the slot is empty or being drained, giving 1 word/cycle with no skid loss.
    assign scan_last_accept = (state_q == ST_SCAN) && scan_valid_q && scan_ready &&
                              (scan_address_q == LAST);
    assign scan_load        = (state_q == ST_SCAN) && !scan_last_accept &&
                              (!scan_valid_q || scan_ready);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            clr_ptr_q      <= '0;
            scan_ptr_q     <= '0;
            scan_address_q <= '0;
            scan_valid_q   <= 1'b0;
            scan_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            scan_ptr_q     <= scan_ptr_d;
            scan_address_q <= scan_address_d;
            scan_valid_q   <= scan_valid_d;
            scan_done_q    <= scan_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                clr_ptr_d = '0;
                if (clear_start)     state_d = ST_CLEAR;
                else if (scan_start) state_d = ST_SCAN;
            end
            ST_CLEAR: begin
                if (clr_ptr_q == LAST) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (scan_last_accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / scan datapath logic
    always_comb begin
        scan_ptr_d     = scan_ptr_q;
        scan_address_d = scan_address_q;
        scan_valid_d   = scan_valid_q;
        scan_done_d    = scan_last_accept;
        clear_busy     = (state_q == ST_CLEAR);
        if (state_q != ST_SCAN) begin
            scan_ptr_d = '0;
        end else if (scan_last_accept) begin
            scan_valid_d = 1'b0;
            scan_ptr_d   = '0;
        end else if (scan_load) begin
            scan_valid_d   = 1'b1;
            scan_address_d = scan_ptr_q;
            scan_ptr_d     = (scan_ptr_q == LAST) ? '0 : scan_ptr_q + 1'b1;
        end
    end

    // Storage is deliberately not reset; a reset mid-clear leaves the partial fill.
    always_ff @(posedge clock) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= CLEAR_VALUE;
        end else if (cpu_wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (cpu_byte_en[i]) mem[cpu_address][8*i +: 8] <= cpu_in[8*i +: 8];
            end
        end
    end

    // Registered reads; both see pre-write contents on a same-cycle write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_out_q   <= '0;
            scan_data_q <= '0;
        end else begin
            cpu_out_q <= cpu_in_range ? mem[cpu_address] : '0;
            if (scan_load) scan_data_q <= mem[scan_ptr_q];
        end
    end

    assign cpu_out      = cpu_out_q;
    assign scan_valid   = scan_valid_q;
    assign scan_data    = scan_data_q;
    assign scan_address = scan_address_q;
    assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_gpu_framebuffer_dp.sv
// Directed + randomized bench for gpu_framebuffer_dp against an array/byte-merge
// reference model of the framebuffer contents and the scan-out ordering.
module tb_gpu_framebuffer_dp;

    localparam int          DW    = 64;
    localparam int          DEPTH = 1200;
    localparam int          AW    = 11;
    localparam logic [63:0] CV    = 64'hC1EA_5A5A_0F0F_7E57;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_in;
    logic          cpu_write;
    logic [7:0]    cpu_byte_en;
    logic [DW-1:0] cpu_out;
    logic          clear_start;
    logic          clear_busy;
    logic          scan_start;
    logic          scan_valid;
    logic          scan_ready;
    logic [DW-1:0] scan_data;
    logic [AW-1:0] scan_address;
    logic          scan_done;

    gpu_framebuffer_dp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_address(cpu_address), .cpu_in(cpu_in), .cpu_write(cpu_write),
        .cpu_byte_en(cpu_byte_en), .cpu_out(cpu_out),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_data(scan_data), .scan_address(scan_address), .scan_done(scan_done)
    );

    always #5 clock = ~clock;

    logic [63:0] model [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_wr(input int a, input logic [63:0] d, input logic [7:0] be);
        cpu_write   = 1'b1;
        cpu_address = AW'(a);
        cpu_in      = d;
        cpu_byte_en = be;
        step();
        cpu_write   = 1'b0;
        if (a < DEPTH)
            for (int b = 0; b < 8; b++)
                if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_address = AW'(i);
            step();
            chk(tag, cpu_out, model[i]);
        end
    endtask

    initial begin
        int          cnt, ncyc, exp_idx;
        logic        done_seen, have_prev, rdy;
        logic [63:0] prev_data, d;
        logic [AW-1:0] prev_addr;

        reset = 1'b1; cpu_address = '0; cpu_in = '0; cpu_write = 1'b0; cpu_byte_en = '0;
        clear_start = 1'b0; scan_start = 1'b0; scan_ready = 1'b0;
        step(); step();
        chk("rst_cpu_out", cpu_out, 64'h0);
        chk("rst_scan_valid", 64'(scan_valid), 64'h0);
        chk("rst_scan_done", 64'(scan_done), 64'h0);
        chk("rst_clear_busy", 64'(clear_busy), 64'h0);
        chk("rst_scan_data", scan_data, 64'h0);
        chk("rst_scan_addr", 64'(scan_address), 64'h0);
        reset = 1'b0;
        step();

        // Clear engine; a write to addr 3 mid-clear must be dropped.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 3000) begin
            if (cnt == 10) begin
                cpu_write = 1'b1; cpu_address = AW'(3); cpu_in = 64'h55; cpu_byte_en = 8'hFF;
            end else begin
                cpu_write = 1'b0;
            end
            cnt++;
            step();
        end
        cpu_write = 1'b0;
        chk("clear_busy_cycles", 64'(cnt), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = CV;
        read_all("clear_read");

        // Byte enables
        cpu_wr(5, 64'h1122334455667788, 8'hFF);
        cpu_wr(5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        cpu_address = AW'(5);
        step();
        chk("byte_en_merge", cpu_out, 64'h11223344FFFFFFFF);

        // Read-during-write returns old data
        cpu_wr(7, 64'h0, 8'hFF);
        cpu_write = 1'b1; cpu_address = AW'(7); cpu_in = 64'hAB; cpu_byte_en = 8'hFF;
        step();
        cpu_write = 1'b0;
        model[7] = 64'hAB;
        chk("rdw_old", cpu_out, 64'h0);
        step();
        chk("rdw_new", cpu_out, 64'hAB);

        // Out-of-range address
        cpu_wr(1300, 64'hDEAD_BEEF_0000_1300, 8'hFF);
        cpu_address = AW'(1300);
        step();
        chk("oor_read", cpu_out, 64'h0);

        // Random byte-enabled writes, then full readback
        repeat (300) begin
            d = {$urandom, $urandom};
            cpu_wr(int'($urandom_range(0, DEPTH - 1)), d, 8'($urandom_range(0, 255)));
        end
        read_all("rand_read");

        // Preload mem[i] = i and scan at full throughput
        for (int i = 0; i < DEPTH; i++) cpu_wr(i, 64'(i), 8'hFF);
        scan_ready = 1'b1; scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("scan_first_invalid", 64'(scan_valid), 64'h0);
        exp_idx = 0; ncyc = 0; done_seen = 1'b0;
        while (!done_seen && ncyc < 5000) begin
            step();
            ncyc++;
            if (scan_done) begin
                done_seen = 1'b1;
                chk("scan_done_valid_low", 64'(scan_valid), 64'h0);
            end
            if (scan_valid) begin
                chk("scan_fast_addr", 64'(scan_address), 64'(exp_idx));
                chk("scan_fast_data", scan_data, model[exp_idx % DEPTH]);
                exp_idx++;
            end
        end
        chk("scan_fast_count", 64'(exp_idx), 64'(DEPTH));
        chk("scan_fast_latency", 64'(ncyc), 64'(DEPTH + 1));
        step();
        chk("scan_done_single", 64'(scan_done), 64'h0);

        // Scan with random backpressure and a CPU write ahead of the fetch pointer
        scan_ready = 1'b0; scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        exp_idx = 0; ncyc = 0; done_seen = 1'b0; have_prev = 1'b0;
        prev_data = '0; prev_addr = '0;
        while (!done_seen && ncyc < 20000) begin
            cpu_write = 1'b0;
            if (scan_done) done_seen = 1'b1;
            if (have_prev) begin
                chk("stall_valid", 64'(scan_valid), 64'h1);
                chk("stall_addr", 64'(scan_address), 64'(prev_addr));
                chk("stall_data", scan_data, prev_data);
            end
            have_prev = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            scan_ready = rdy;
            if (scan_valid && !done_seen) begin
                if (rdy) begin
                    chk("scan_rnd_addr", 64'(scan_address), 64'(exp_idx));
                    chk("scan_rnd_data", scan_data, model[exp_idx % DEPTH]);
                    exp_idx++;
                    if (exp_idx == 100) begin
                        cpu_write = 1'b1; cpu_address = AW'(1100);
                        cpu_in = 64'hFEED_FACE_1100_0001; cpu_byte_en = 8'hFF;
                        model[1100] = 64'hFEED_FACE_1100_0001;
                    end
                end else begin
                    have_prev = 1'b1;
                    prev_addr = scan_address;
                    prev_data = scan_data;
                end
            end
            step();
            ncyc++;
        end
        cpu_write = 1'b0;
        chk("scan_rnd_done", 64'(done_seen), 64'h1);
        chk("scan_rnd_count", 64'(exp_idx), 64'(DEPTH));
        chk("scan_rnd_done_single", 64'(scan_done), 64'h0);

        // Async reset at word 600 of a scan
        scan_ready = 1'b1; scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        ncyc = 0;
        while (!(scan_valid && scan_address == AW'(600)) && ncyc < 5000) begin
            step();
            ncyc++;
        end
        chk("scan_reach_600", 64'(scan_address), 64'd600);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_scan_valid", 64'(scan_valid), 64'h0);
        chk("rst_mid_scan_addr", 64'(scan_address), 64'h0);
        chk("rst_mid_scan_data", scan_data, 64'h0);
        #2 reset = 1'b0;
        step();
        cpu_address = AW'(1100);
        step();
        chk("mem_kept_after_reset", cpu_out, model[1100]);

        // Async reset mid-clear: first 99 words cleared, rest untouched
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (99) step();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_clear_busy", 64'(clear_busy), 64'h0);
        #2 reset = 1'b0;
        step();
        for (int i = 0; i < 99; i++) model[i] = CV;
        cpu_address = AW'(50);  step(); chk("part_clear_50", cpu_out, model[50]);
        cpu_address = AW'(98);  step(); chk("part_clear_98", cpu_out, model[98]);
        cpu_address = AW'(99);  step(); chk("part_clear_99", cpu_out, model[99]);
        cpu_address = AW'(1000); step(); chk("part_clear_1000", cpu_out, model[1000]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
